// File: rtl/vga_pixel_pipeline_if.sv
// Pixel bus between the VGA pipeline, its upstream color source and the DAC pins.
// The master is the pipeline. It drives coordinates and DAC levels and receives color.
interface vga_pixel_pipeline_if #(
  parameter int CW    = 8,
  parameter int CNT_W = 10
);
  logic [3*CW-1:0]  color_in;
  logic [CNT_W-1:0] x_out;
  logic [CNT_W-1:0] y_out;
  logic             req;
  logic [CW-1:0]    red;
  logic [CW-1:0]    green;
  logic [CW-1:0]    blue;
  logic             hsync_n;
  logic             vsync_n;
  logic             blank_n;
  logic             sync_n;

  modport master (
    input  color_in,
    output x_out, y_out, req, red, green, blue, hsync_n, vsync_n, blank_n, sync_n
  );

  modport slave (
    output color_in,
    input  x_out, y_out, req, red, green, blue, hsync_n, vsync_n, blank_n, sync_n
  );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// VGA timing generator and pixel output stage with a fixed color-source latency.
// Optional macro VGA_PIPE_TEST_PATTERN_EN adds test_mode and eight vertical color bars.
module vga_pixel_pipeline #(
  parameter int CW       = 8,
  parameter int CNT_W    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int LATENCY  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
`ifdef VGA_PIPE_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  output logic frame_start,
  vga_pixel_pipeline_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             SYNC_OFF_C = (SYNC_POL == 0) ? 1'b1 : 1'b0;
  localparam logic             SYNC_ON_C  = ~SYNC_OFF_C;

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             frame_start_q, frame_start_d;
  logic             act_raw_s, hs_raw_s, vs_raw_s;
  logic             act_dly_s, hs_dly_s, vs_dly_s;
  logic [3*CW-1:0]  rgb_q, rgb_d;
  logic             hsync_n_q, hsync_n_d;
  logic             vsync_n_q, vsync_n_d;
  logic             blank_n_q, blank_n_d;
  logic             sync_n_q, sync_n_d;

  // Counter next state: h wraps into v, and the double wrap marks a frame start
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (h_q == H_LAST_C) begin
      h_d = '0;
      if (v_q == V_LAST_C) begin
        v_d           = '0;
        frame_start_d = 1'b1;
      end else begin
        v_d = v_q + CNT_W'(1);
      end
    end else begin
      h_d = h_q + CNT_W'(1);
    end
  end

  // Counter registers; frame_start is a single clk wide even with sparse pix_en
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
    end else begin
      h_q           <= h_q;
      v_q           <= v_q;
      frame_start_q <= 1'b0;
    end
  end

  assign act_raw_s = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_raw_s  = (h_q >= HS_START_C) && (h_q < HS_END_C);
  assign vs_raw_s  = (v_q >= VS_START_C) && (v_q < VS_END_C);

`ifdef VGA_PIPE_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);
  logic [CNT_W-1:0] x_dly_s;
  logic [CNT_W-1:0] bar_s;
  logic [3*CW-1:0]  pat_s;
  assign bar_s = x_dly_s / BAR_W_C;
  assign pat_s = {{CW{bar_s[2]}}, {CW{bar_s[1]}}, {CW{bar_s[0]}}};
`endif

  generate
    if (LATENCY == 0) begin : g_nodly
      assign act_dly_s = act_raw_s;
      assign hs_dly_s  = hs_raw_s;
      assign vs_dly_s  = vs_raw_s;
`ifdef VGA_PIPE_TEST_PATTERN_EN
      assign x_dly_s   = h_q;
`endif
    end else begin : g_dly
      logic [LATENCY-1:0] act_sr_q, hs_sr_q, vs_sr_q;

      // Flag alignment line, flushed to inactive/deasserted on reset
      always_ff @(posedge clk) begin
        if (reset) begin
          act_sr_q <= '0;
          hs_sr_q  <= '0;
          vs_sr_q  <= '0;
        end else if (pix_en) begin
          act_sr_q[0] <= act_raw_s;
          hs_sr_q[0]  <= hs_raw_s;
          vs_sr_q[0]  <= vs_raw_s;
          for (int i = 1; i < LATENCY; i++) begin
            act_sr_q[i] <= act_sr_q[i-1];
            hs_sr_q[i]  <= hs_sr_q[i-1];
            vs_sr_q[i]  <= vs_sr_q[i-1];
          end
        end else begin
          act_sr_q <= act_sr_q;
          hs_sr_q  <= hs_sr_q;
          vs_sr_q  <= vs_sr_q;
        end
      end

      assign act_dly_s = act_sr_q[LATENCY-1];
      assign hs_dly_s  = hs_sr_q[LATENCY-1];
      assign vs_dly_s  = vs_sr_q[LATENCY-1];

`ifdef VGA_PIPE_TEST_PATTERN_EN
      logic [CNT_W-1:0] x_sr_q [LATENCY];

      // Horizontal position delayed alongside the flags so bars line up with blank_n
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++) x_sr_q[i] <= '0;
        end else if (pix_en) begin
          x_sr_q[0] <= h_q;
          for (int i = 1; i < LATENCY; i++) x_sr_q[i] <= x_sr_q[i-1];
        end else begin
          for (int i = 0; i < LATENCY; i++) x_sr_q[i] <= x_sr_q[i];
        end
      end

      assign x_dly_s = x_sr_q[LATENCY-1];
`endif
    end
  endgenerate

  // Output stage next state: color gated by the delayed active flag, syncs mapped to polarity
  always_comb begin
    rgb_d     = '0;
    blank_n_d = act_dly_s;
    hsync_n_d = hs_dly_s ? SYNC_ON_C : SYNC_OFF_C;
    vsync_n_d = vs_dly_s ? SYNC_ON_C : SYNC_OFF_C;
    sync_n_d  = ~(hs_dly_s | vs_dly_s);
    if (act_dly_s) begin
`ifdef VGA_PIPE_TEST_PATTERN_EN
      if (test_mode) begin
        rgb_d = pat_s;
      end else begin
        rgb_d = vga.color_in;
      end
`else
      rgb_d = vga.color_in;
`endif
    end else begin
      rgb_d = '0;
    end
  end

  // Output registers feeding the DAC pins
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hsync_n_q <= SYNC_OFF_C;
      vsync_n_q <= SYNC_OFF_C;
      sync_n_q  <= 1'b1;
    end else if (pix_en) begin
      rgb_q     <= rgb_d;
      blank_n_q <= blank_n_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      sync_n_q  <= sync_n_d;
    end else begin
      rgb_q     <= rgb_q;
      blank_n_q <= blank_n_q;
      hsync_n_q <= hsync_n_q;
      vsync_n_q <= vsync_n_q;
      sync_n_q  <= sync_n_q;
    end
  end

  assign vga.x_out   = h_q;
  assign vga.y_out   = v_q;
  assign vga.req     = act_raw_s;
  assign vga.red     = rgb_q[CW-1:0];
  assign vga.green   = rgb_q[2*CW-1:CW];
  assign vga.blue    = rgb_q[3*CW-1:2*CW];
  assign vga.hsync_n = hsync_n_q;
  assign vga.vsync_n = vsync_n_q;
  assign vga.blank_n = blank_n_q;
  assign vga.sync_n  = sync_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Scoreboard bench for vga_pixel_pipeline on a reduced raster (24x10) so whole frames run quickly.
// Expected pixels are queued per coordinate and popped when the pipeline emits them.
module tb_vga_pixel_pipeline;
  localparam int CW = 8, CNT_W = 10, LAT = 2, SP = 0;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam logic SOFF = (SP == 0) ? 1'b1 : 1'b0;
  localparam logic [27:0] RESET_VEC = {24'h0, SOFF, SOFF, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic test_mode = 1'b0;
  logic frame_start;

  vga_pixel_pipeline_if #(.CW(CW), .CNT_W(CNT_W)) vif();

  vga_pixel_pipeline #(
    .CW(CW), .CNT_W(CNT_W),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
`ifdef VGA_PIPE_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .frame_start(frame_start),
    .vga(vif.master)
  );

  always #5 clk = ~clk;

  logic [27:0] exp_q[$];
  logic [27:0] last_exp;
  logic [23:0] hist [0:LAT];
  int mh, mv;
  bit ones_mode;
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (h=%0d v=%0d t=%0t)", tag, obs, exp, mh, mv, $time);
    end
  endtask

  function automatic logic [23:0] color_of(input int h, input int v);
    logic [7:0] hb, vb;
    int idx;
    hb = h[7:0];
    vb = v[7:0];
    idx = h / (HA / 8);
    if (test_mode) return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    else if (ones_mode) return 24'hFFFFFF;
    else return {hb, vb, 8'hA5};
  endfunction

  function automatic logic [27:0] exp_vec(input int h, input int v, input logic [23:0] col);
    bit act, hs, vs;
    logic [23:0] rgb;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
    vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
    rgb = act ? {col[7:0], col[15:8], col[23:16]} : 24'h0;
    return {rgb, hs ? ~SOFF : SOFF, vs ? ~SOFF : SOFF, act, ~(hs | vs)};
  endfunction

  task automatic sb_reset();
    exp_q.delete();
    mh = 0;
    mv = 0;
    for (int i = 0; i < LAT; i++) exp_q.push_back(RESET_VEC);
    for (int i = 0; i <= LAT; i++) hist[i] = 24'h0;
    hist[0] = color_of(0, 0);
    exp_q.push_back(exp_vec(0, 0, hist[0]));
    last_exp = RESET_VEC;
  endtask

  // One clk: drive at negedge, compare at the next negedge
  task automatic step(input bit en);
    bit fs_exp;
    pix_en = en;
    vif.color_in = hist[LAT];
    @(posedge clk);
    @(negedge clk);
    fs_exp = 1'b0;
    if (en) begin
      fs_exp = (mh == HT - 1) && (mv == VT - 1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      if (exp_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
      else last_exp = exp_q.pop_front();
      for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = color_of(mh, mv);
      exp_q.push_back(exp_vec(mh, mv, hist[0]));
    end
    check_eq("pix", {vif.red, vif.green, vif.blue, vif.hsync_n, vif.vsync_n, vif.blank_n, vif.sync_n}, last_exp);
    check_eq("xy", {vif.x_out, vif.y_out}, {mh[CNT_W-1:0], mv[CNT_W-1:0]});
    check_eq("req", vif.req, (mh < HA) && (mv < VA));
    check_eq("frame_start", frame_start, fs_exp);
  endtask

  // Reset with pix_en high to confirm reset priority
  task automatic do_reset();
    reset = 1'b1;
    pix_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_pix", {vif.red, vif.green, vif.blue, vif.hsync_n, vif.vsync_n, vif.blank_n, vif.sync_n}, RESET_VEC);
    check_eq("rst_xy", {vif.x_out, vif.y_out}, 20'h0);
    check_eq("rst_fs", frame_start, 1'b0);
    reset = 1'b0;
    sb_reset();
  endtask

  initial begin
    int guard;
    ones_mode = 1'b0;
    vif.color_in = 24'h0;
    mh = 0;
    mv = 0;
    @(negedge clk);
    do_reset();

    // Two full frames plus a little, coordinate-derived colors
    for (int i = 0; i < 2 * HT * VT + 20; i++) step(1'b1);

    // Saturated source: blanking must still force black
    ones_mode = 1'b1;
    for (int i = 0; i < HT * VT + 20; i++) step(1'b1);
    ones_mode = 1'b0;

    // Sparse pixel enable: outputs hold between ticks
    for (int i = 0; i < HT * VT + 20; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
    end

    // Mid-frame reset at h=10, v=3
    guard = 0;
    while (!(mh == 10 && mv == 3) && guard < 2 * HT * VT) begin
      step(1'b1);
      guard++;
    end
    check_eq("mid_reach", {mh[CNT_W-1:0], mv[CNT_W-1:0]}, {10'd10, 10'd3});
    do_reset();
    step(1'b1);
    check_eq("x_after_rst", vif.x_out, 10'd1);
    for (int i = 0; i < HT * VT; i++) step(1'b1);

`ifdef VGA_PIPE_TEST_PATTERN_EN
    test_mode = 1'b1;
    do_reset();
    for (int i = 0; i < HT * VT + 20; i++) step(1'b1);
    test_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_pixel_pipeline.md
Name: vga_pixel_pipeline

Overview:
- Parametrised successor to the VGA output painter.
- Generates all VGA timing internally, with configurable porches, sync widths and polarity.
- Emits pixel coordinates to an upstream color source and accepts that source's color a fixed LATENCY pixel-ticks later.
- Drives registered R/G/B, hsync_n, vsync_n, blank_n and sync_n, all aligned to the same pixel.
- Sits between the frame/sprite renderer and the ADV7123-style DAC pins.

Parameters:
- CW, 8, bits per color channel.
- CNT_W, 10, width of the h/v counters and coordinate outputs.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of hsync/vsync pulses (0 = active-low).
- LATENCY, 2, pixel-ticks from coordinate out to color in; legal range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-clock enable; one pulse per pixel
- color_in  in  3*CW  {blue,green,red} from the color source
- x_out  out  CNT_W  current horizontal count
- y_out  out  CNT_W  current vertical count
- req  out  1  high when (x_out,y_out) is inside the active area
- red  out  CW  red to DAC
- green  out  CW  green to DAC
- blue  out  CW  blue to DAC
- hsync_n  out  1  horizontal sync, level per SYNC_POL
- vsync_n  out  1  vertical sync, level per SYNC_POL
- blank_n  out  1  low outside active area
- sync_n  out  1  composite sync, low while hsync or vsync is asserted
- frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL likewise (525).
- Reset is synchronous and active-high. On the clock edge with reset=1:
  - h and v counters clear to 0.
  - Pipeline is flushed: all delayed active flags 0, delayed sync flags deasserted.
  - red/green/blue = 0, blank_n = 0, sync_n = 1, hsync_n and vsync_n at their deasserted level, frame_start = 0.
  - Reset takes priority over pix_en.
- While pix_en = 0, every register holds its value.
- Counters, on each pix_en tick:
  - h increments; at h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 together with h = H_TOTAL-1, both wrap to 0, and frame_start pulses high for exactly that one clk.
  - frame_start is not pulsed by reset release.
- x_out = h and y_out = v, straight from the counter registers.
- req = (h < H_ACTIVE) && (v < V_ACTIVE).
- Raw flags at counter stage:
  - hs_raw = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - act_raw = req.
- Alignment delay line: act_raw, hs_raw and vs_raw pass through LATENCY pix_en-gated stages. LATENCY = 0 means no extra stage.
- Output register, updated on each pix_en tick from the delayed flags:
  - RGB = color_in if delayed active, else 0.
  - blank_n = delayed active.
  - hsync_n / vsync_n = delayed hs / vs, mapped through SYNC_POL.
  - sync_n = ~(delayed hs | delayed vs).
- Color contract:
  - Coordinate (x,y) presented after tick t must have its color valid on color_in at tick t+LATENCY.
  - That color appears on RGB after tick t+LATENCY, together with its own blank and sync levels.
  - Source contract: color_in is only sampled when pix_en = 1.
- Mid-frame reset: the frame is abandoned. The next frame starts at (0,0), with no partial pixels emitted from the pipeline.

Optional Feature:
- Macro: VGA_PIPE_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode = 1, color_in is ignored and RGB shows 8 vertical color bars, each H_ACTIVE/8 wide.
  - Bar index drives {blue,green,red} = {idx[2],idx[1],idx[0]} replicated to CW bits (all ones or all zeros per channel).
  - x is delayed by LATENCY stages, so bars align with blank_n.
  - Blanking and sync are unchanged.
- When not defined: the test_mode port is absent and RGB always comes from color_in.

Test Plan:
- Reset, then defaults with pix_en = 1 every clk: hsync_n low for exactly 96 ticks starting at h=656 (plus LATENCY); line period 800 ticks; vsync_n low for 2 lines starting at line 490 (plus LATENCY); frame period 420000 ticks; frame_start pulses once per frame.
- LATENCY=2, color source returns {x[7:0], y[7:0], 8'hA5}: each active RGB equals the value for the coordinate presented 2 ticks earlier; first visible pixel of line 0 is red=A5, green=00, blue=00.
- color_in forced to all-ones: RGB = 0 and blank_n = 0 for h >= 640 or v >= 480 after the delay; sync_n low during both hsync and vsync intervals.
- pix_en asserted 1 clk in 4: all outputs and counters hold between ticks; timing in ticks is identical to the pix_en = 1 run.
- Reset asserted mid-line at h=300, v=100: after the next edge, counters = 0, RGB = 0, blank_n = 0, syncs deasserted, no frame_start; the first following tick shows x_out = 1.
- VGA_PIPE_TEST_PATTERN_EN defined, test_mode = 1: pixels 0..79 black, 80..159 red (red=FF), …, 560..639 white.
